// File: rtl/cmos_frame_capture_if.sv
// Write port from the camera capture block toward the DDR write FIFO.
interface cmos_frame_capture_if #(parameter int ADDR_W = 24);
  logic              wr_valid;
  logic              wr_ready;
  logic [63:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;

  modport master (output wr_valid, wr_data, wr_addr, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_addr, output wr_ready);
endinterface

// File: rtl/cmos_frame_capture.sv
// Camera pixel receiver: frame-aligned 8:1 byte packing into a 4-deep write buffer.
// Optional geometry checking is built when CAP_GEOM_CHECK_EN is defined.
module cmos_frame_capture #(
  parameter int   IMG_HDISP = 1280,
  parameter int   IMG_VDISP = 768,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   ADDR_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_data,
  cmos_frame_capture_if.master wr,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic                 ovf,
  output logic                 geom_err
);

  typedef enum logic [2:0] {IDLE, ARM, CAPT, DONE, SYNC} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } word_t;

  state_t st, nxt;
  logic   vs_act, vs_q, fbeg, fend;
  logic   start_c, stop_q, pend_q;

  // Edges compare the registered level against the live level.
  assign vs_act = (cam_vsync == VSYNC_POL);
  assign fbeg   = vs_q & ~vs_act;
  assign fend   = ~vs_q & vs_act;

  always_comb begin
    nxt     = st;
    start_c = 1'b0;
    unique case (st)
      IDLE: if (cap_en) nxt = ARM;
      ARM, SYNC: begin
        if (!cap_en) nxt = IDLE;
        else if (fbeg) begin
          nxt     = CAPT;
          start_c = 1'b1;
        end
      end
      CAPT: if (fbeg || fend) nxt = DONE;
      DONE: begin
        if (cap_en && !stop_q) begin
          if (pend_q || fbeg) begin
            nxt     = CAPT;
            start_c = 1'b1;
          end else nxt = SYNC;
        end else nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // packer
  logic [2:0]      bcnt;
  logic [7:0][7:0] pack_q, push_data;
  logic            href_q, pix, lend, push;

  assign pix  = (st == CAPT) && cam_href;
  assign lend = (st == CAPT) && href_q && !cam_href;
  assign push = (pix && bcnt == 3'd7) || (lend && bcnt != 3'd0) ||
                (st == DONE && bcnt != 3'd0);

  // Unwritten bytes are already zero, so a partial word is self-padded.
  always_comb begin
    push_data = pack_q;
    if (pix) push_data[7] = cam_data;
  end

  // write buffer
  word_t             mem [4];
  logic [1:0]        wp, rp;
  logic [2:0]        cnt;
  logic              full, empty, pop, wen, drop;
  logic [ADDR_W-1:0] addr_q;

  assign full  = (cnt == 3'd4);
  assign empty = (cnt == 3'd0);
  assign pop   = wr.wr_valid & wr.wr_ready;
  assign wen   = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign wr.wr_valid = !empty;
  assign wr.wr_data  = empty ? 64'd0 : mem[rp].data;
  assign wr.wr_addr  = empty ? '0 : mem[rp].addr;

  always_ff @(posedge clk)
    if (wen) mem[wp] <= {addr_q, 64'(push_data)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      vs_q        <= 1'b0;
      stop_q      <= 1'b0;
      pend_q      <= 1'b0;
      href_q      <= 1'b0;
      bcnt        <= 3'd0;
      pack_q      <= '0;
      wp          <= 2'd0;
      rp          <= 2'd0;
      cnt         <= 3'd0;
      addr_q      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'd0;
      ovf         <= 1'b0;
    end else begin
      st          <= nxt;
      vs_q        <= vs_act;
      stop_q      <= (st == CAPT) && (stop_q || !cap_en);
      pend_q      <= (st == CAPT) && fbeg;
      href_q      <= cam_href;
      frame_start <= start_c;
      frame_done  <= (st == DONE);
      if (st == DONE) frame_cnt <= frame_cnt + 16'd1;

      if (st != CAPT || lend) begin
        bcnt   <= 3'd0;
        pack_q <= '0;
      end else if (pix) begin
        if (bcnt == 3'd7) pack_q <= '0;
        else              pack_q[bcnt] <= cam_data;
        bcnt <= bcnt + 3'd1;
      end

      if (wen) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(wen) - 3'(pop);

      // Dropped words still consume an address to keep frame positions.
      if (start_c)   addr_q <= '0;
      else if (push) addr_q <= addr_q + ADDR_W'(1);

      if (st == IDLE) ovf <= 1'b0;
      else if (drop)  ovf <= 1'b1;
    end
  end

`ifdef CAP_GEOM_CHECK_EN
  logic [15:0] pcnt, lcnt, lines_eff;
  logic        geom_bad;

  assign lines_eff = lcnt + 16'(pcnt != 16'd0);
  assign geom_bad  = (lend && pcnt != 16'(IMG_HDISP)) ||
                     (st == DONE && ((pcnt != 16'd0 && pcnt != 16'(IMG_HDISP)) ||
                                     lines_eff != 16'(IMG_VDISP)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt     <= 16'd0;
      lcnt     <= 16'd0;
      geom_err <= 1'b0;
    end else begin
      if (start_c) begin
        pcnt <= 16'd0;
        lcnt <= 16'd0;
      end else if (pix) pcnt <= pcnt + 16'd1;
      else if (lend) begin
        pcnt <= 16'd0;
        lcnt <= lcnt + 16'd1;
      end
      if (st == IDLE)    geom_err <= 1'b0;
      else if (geom_bad) geom_err <= 1'b1;
    end
  end
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Directed bench for cmos_frame_capture: two instances (active-high and inverted vsync)
// driven by identical stimulus, each checked against a queue of model-packed words.
module tb_cmos_frame_capture;

`ifdef CAP_GEOM_CHECK_EN
  localparam logic GEOM_EXP = 1'b1;
`else
  localparam logic GEOM_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cap_en, vs, vs_n, href, rdy;
  logic [7:0]  data;
  logic        fs0, fd0, fs1, fd1, ovf0, ovf1, ge0, ge1;
  logic [15:0] fc0, fc1;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int done0 = 0, done1 = 0, start0 = 0;
  logic [87:0] q0[$];
  logic [87:0] q1[$];

  always #5 clk = ~clk;
  assign vs_n = ~vs;

  cmos_frame_capture_if #(.ADDR_W(24)) w0 ();
  cmos_frame_capture_if #(.ADDR_W(24)) w1 ();
  assign w0.wr_ready = rdy;
  assign w1.wr_ready = rdy;

  cmos_frame_capture #(.IMG_HDISP(16), .IMG_VDISP(4), .VSYNC_POL(1'b1), .ADDR_W(24)) dut0 (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cam_vsync(vs), .cam_href(href), .cam_data(data),
    .wr(w0), .frame_start(fs0), .frame_done(fd0), .frame_cnt(fc0), .ovf(ovf0), .geom_err(ge0));

  cmos_frame_capture #(.IMG_HDISP(16), .IMG_VDISP(4), .VSYNC_POL(1'b0), .ADDR_W(24)) dut1 (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cam_vsync(vs_n), .cam_href(href), .cam_data(data),
    .wr(w1), .frame_start(fs1), .frame_done(fd1), .frame_cnt(fc1), .ovf(ovf1), .geom_err(ge1));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fd0) done0++;
    if (fd1) done1++;
    if (fs0) start0++;
    if (w0.wr_valid && w0.wr_ready) begin
      check("q0_has_word", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) check("word0", 128'({w0.wr_addr, w0.wr_data}), 128'(q0.pop_front()));
    end
    if (w1.wr_valid && w1.wr_ready) begin
      check("q1_has_word", 128'(q1.size() != 0), 128'(1));
      if (q1.size() != 0) check("word1", 128'({w1.wr_addr, w1.wr_data}), 128'(q1.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_word(input bit en, input int a, input logic [63:0] w);
    if (en) begin
      q0.push_back({24'(a), w});
      q1.push_back({24'(a), w});
    end
  endtask

  // One frame: sync interval, begin edge, then lines of pixels base+index.
  task automatic frame(input int lines, input int ppl, input bit expect_w, input int keep,
                       input int en_line, input int rst_line, input logic [7:0] base);
    logic [63:0] w = '0;
    int b = 0, a = 0, kept = 0;
    bit live = expect_w;
    vs = 1'b1; cyc(3);
    vs = 1'b0; cyc(3);
    for (int l = 0; l < lines; l++) begin
      if (l == en_line) cap_en = 1'b1;
      for (int i = 0; i < ppl; i++) begin
        if (l == rst_line && i == 4) begin
          rst = 1'b1;
          #2;
          check("rst_valid0", 128'(w0.wr_valid), 128'(0));
          check("rst_valid1", 128'(w1.wr_valid), 128'(0));
          check("rst_fcnt0", 128'(fc0), 128'(0));
          check("rst_addr0", 128'(w0.wr_addr), 128'(0));
          check("rst_ovf0", 128'(ovf0), 128'(0));
          check("rst_geom0", 128'(ge0), 128'(0));
          cyc(1);
          rst = 1'b0;
          live = 1'b0;
        end
        href = 1'b1;
        data = base + 8'(l * ppl + i);
        w[b*8 +: 8] = data;
        b++;
        if (b == 8) begin
          exp_word(live && kept < keep, a, w);
          kept++; a++; w = '0; b = 0;
        end
        cyc(1);
      end
      href = 1'b0;
      if (b != 0) begin
        exp_word(live && kept < keep, a, w);
        kept++; a++; w = '0; b = 0;
      end
      cyc(2);
    end
  endtask

  task automatic end_frame();
    vs = 1'b1;
    cyc(4);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      cyc(1);
      n++;
    end
    check("drain", 128'(q0.size() + q1.size()), 128'(0));
  endtask

  initial begin
    rst = 1'b1; cap_en = 1'b0; vs = 1'b0; href = 1'b0; data = 8'd0; rdy = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("init_valid", 128'(w0.wr_valid), 128'(0));
    check("init_data", 128'(w0.wr_data), 128'(0));
    check("init_fcnt", 128'(fc0), 128'(0));
    check("init_ovf", 128'(ovf0), 128'(0));
    check("init_geom", 128'(ge0), 128'(0));

    // basic frame, both sync polarities
    cap_en = 1'b1; cyc(2);
    frame(4, 16, 1'b1, 99, -1, -1, 8'h00); end_frame();
    check("t1_fcnt0", 128'(fc0), 128'(1));
    check("t1_fcnt1", 128'(fc1), 128'(1));
    check("t1_done0", 128'(done0), 128'(1));
    check("t1_start0", 128'(start0), 128'(1));
    drain();

    // enable raised mid-frame: nothing until the next frame begins
    cap_en = 1'b0; cyc(2);
    frame(4, 16, 1'b0, 99, 1, -1, 8'h20); end_frame();
    frame(4, 16, 1'b1, 99, -1, -1, 8'h40); end_frame();
    check("t2_fcnt0", 128'(fc0), 128'(2));
    drain();

    // sink stalled for a whole frame: first four held, the rest dropped
    rdy = 1'b0;
    frame(4, 16, 1'b1, 4, -1, -1, 8'h80); end_frame();
    check("t3_ovf0", 128'(ovf0), 128'(1));
    check("t3_ovf1", 128'(ovf1), 128'(1));
    check("t3_valid", 128'(w0.wr_valid), 128'(1));
    check("t3_addr", 128'(w0.wr_addr), 128'(0));
    check("t3_data", 128'(w0.wr_data), 128'(q0[0][63:0]));
    cyc(5);
    check("t3_hold", 128'(w0.wr_data), 128'(q0[0][63:0]));
    rdy = 1'b1;
    drain();
    frame(4, 16, 1'b1, 99, -1, -1, 8'h90); end_frame();
    check("t3_fcnt", 128'(fc0), 128'(4));
    check("t3_ovf_sticky", 128'(ovf0), 128'(1));
    drain();

    // short single-line frame: padded partial word and geometry error
    frame(1, 12, 1'b1, 99, -1, -1, 8'hA0); end_frame();
    check("t4_geom0", 128'(ge0), 128'(GEOM_EXP));
    check("t4_geom1", 128'(ge1), 128'(GEOM_EXP));
    check("t4_fcnt", 128'(fc0), 128'(5));
    drain();
    frame(4, 16, 1'b1, 99, -1, -1, 8'hB0); end_frame();
    check("t4_geom_sticky", 128'(ge0), 128'(GEOM_EXP));
    drain();
    cap_en = 1'b0; cyc(3);
    check("t4_geom_clr", 128'(ge0), 128'(0));
    check("t4_ovf_clr", 128'(ovf0), 128'(0));

    // reset during the third line, capture resumes at the next frame
    cap_en = 1'b1; cyc(2);
    frame(4, 16, 1'b1, 99, -1, 2, 8'hC0); end_frame();
    check("t5_fcnt_after_rst", 128'(fc0), 128'(0));
    frame(4, 16, 1'b1, 99, -1, -1, 8'hD0); end_frame();
    check("t5_fcnt0", 128'(fc0), 128'(1));
    check("t5_fcnt1", 128'(fc1), 128'(1));
    drain();
    check("tot_done0", 128'(done0), 128'(7));
    check("tot_done1", 128'(done1), 128'(7));
    check("tot_start0", 128'(start0), 128'(8));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
